// File: rtl/pc_stack_unit.sv
// Fetch-stage program counter with priority-encoded updates and a return-address stack.
// Stack full/empty derive only from the entry count; fault flags are sticky until reset.
module pc_stack_unit #(
  parameter int unsigned      WIDTH     = 16,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     inc,
  input  logic                     add,
  input  logic                     sub,
  input  logic                     jmp,
  input  logic                     call,
  input  logic                     ret,
  input  logic [WIDTH-1:0]         offset,
  input  logic [WIDTH-1:0]         target,
  output logic [WIDTH-1:0]         pc,
  output logic [$clog2(DEPTH):0]   sp_count,
  output logic                     stack_full,
  output logic                     stack_empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned SPW = AW + 1;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_STALL,
    OP_RET,
    OP_CALL,
    OP_JMP,
    OP_ADD,
    OP_SUB,
    OP_INC
  } op_e;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [WIDTH-1:0] stack_q [DEPTH];

  logic [6:0]       req;
  logic [6:0]       gnt;
  op_e              op;
  logic             full;
  logic             empty;
  logic             push;
  logic [AW-1:0]    push_idx;
  logic [AW-1:0]    pop_idx;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] tos;

  // Bit 0 is highest priority; isolating the lowest set bit
  // leaves a one-hot grant for the decoder below.
  assign req = {inc, sub, add, jmp, call, ret, stall};
  assign gnt = req & (~req + 7'd1);

  always_comb begin
    op = OP_HOLD;
    unique case (1'b1)
      gnt[0]:  op = OP_STALL;
      gnt[1]:  op = OP_RET;
      gnt[2]:  op = OP_CALL;
      gnt[3]:  op = OP_JMP;
      gnt[4]:  op = OP_ADD;
      gnt[5]:  op = OP_SUB;
      gnt[6]:  op = OP_INC;
      default: op = OP_HOLD;
    endcase
  end

  assign full     = (sp_q == SPW'(DEPTH));
  assign empty    = (sp_q == '0);
  assign pc_inc   = pc_q + WIDTH'(1);
  assign push_idx = sp_q[AW-1:0];
  assign pop_idx  = AW'(sp_q - SPW'(1));
  assign tos      = stack_q[pop_idx];

  always_comb begin
    pc_d  = pc_q;
    sp_d  = sp_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    unique case (op)
      OP_RET: begin
        if (empty) begin
          unf_d = 1'b1;
        end else begin
          pc_d = tos;
          sp_d = sp_q - SPW'(1);
        end
      end
      OP_CALL: begin
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          push = 1'b1;
          sp_d = sp_q + SPW'(1);
          pc_d = target;
        end
      end
      OP_JMP:  pc_d = target;
      OP_ADD:  pc_d = pc_q + offset;
      OP_SUB:  pc_d = pc_q - offset;
      OP_INC:  pc_d = pc_inc;
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= RESET_VEC;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Entries carry no reset; only the count says what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  assign pc          = pc_q;
  assign sp_count    = sp_q;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Randomised and directed bench for pc_stack_unit.
// A queue-based reference model predicts pc, stack depth and flags.
module tb_pc_stack_unit;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        stall, inc, add, sub, jmp, call, ret;
  logic [15:0] offset, target;
  logic [15:0] pc;
  logic [2:0]  sp_count;
  logic        stack_full, stack_empty, overflow, underflow;

  int vectors;
  int errors;

  logic [15:0] m_pc;
  logic [15:0] m_stk [$];
  logic        m_ovf, m_unf;

  pc_stack_unit #(
    .WIDTH(16), .DEPTH(DEPTH), .RESET_VEC(16'h0000)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .inc(inc), .add(add), .sub(sub), .jmp(jmp),
    .call(call), .ret(ret),
    .offset(offset), .target(target),
    .pc(pc), .sp_count(sp_count),
    .stack_full(stack_full), .stack_empty(stack_empty),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [22:0] dut_vec();
    return {pc, sp_count, stack_full, stack_empty, overflow, underflow};
  endfunction

  function automatic logic [22:0] exp_vec();
    return {m_pc, 3'(m_stk.size()), m_stk.size() == DEPTH,
            m_stk.size() == 0, m_ovf, m_unf};
  endfunction

  task automatic model_clear();
    m_pc = 16'h0000;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Applies one clock edge's worth of the priority rules to the model.
  task automatic model_step();
    if (stall) begin
    end else if (ret) begin
      if (m_stk.size() != 0) m_pc = m_stk.pop_back();
      else m_unf = 1'b1;
    end else if (call) begin
      if (m_stk.size() == DEPTH) m_ovf = 1'b1;
      else begin
        m_stk.push_back(m_pc + 16'd1);
        m_pc = target;
      end
    end else if (jmp) m_pc = target;
    else if (add) m_pc = m_pc + offset;
    else if (sub) m_pc = m_pc - offset;
    else if (inc) m_pc = m_pc + 16'd1;
  endtask

  task automatic idle();
    {stall, inc, add, sub, jmp, call, ret} = '0;
    offset = '0;
    target = '0;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    idle();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (dut_vec() !== {16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset got=%h exp=%h", dut_vec(),
               {16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_inc();
    logic [15:0] want;
    inc = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      want = 16'(i);
      vectors++;
      if (pc !== want || sp_count !== 3'd0 || stack_empty !== 1'b1) begin
        errors++;
        $display("FAIL inc%0d pc=%h sp=%0d empty=%b exp pc=%h sp=0 empty=1",
                 i, pc, sp_count, stack_empty, want);
      end
    end
    idle();
  endtask

  task automatic test_add_sub();
    logic [15:0] want [3];
    want[0] = 16'h00A6;
    want[1] = 16'h0092;
    want[2] = 16'h0092;
    jmp = 1'b1; target = 16'h0001;
    step();
    idle(); add = 1'b1; offset = 16'h00A5;
    step();
    vectors++;
    if (pc !== want[0]) begin
      errors++; $display("FAIL add pc=%h exp=%h", pc, want[0]);
    end
    idle(); sub = 1'b1; offset = 16'h0014;
    step();
    vectors++;
    if (pc !== want[1]) begin
      errors++; $display("FAIL sub pc=%h exp=%h", pc, want[1]);
    end
    idle();
    step();
    vectors++;
    if (pc !== want[2]) begin
      errors++; $display("FAIL hold pc=%h exp=%h", pc, want[2]);
    end
    vectors++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL add_sub_model got=%h exp=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_call_ret();
    idle(); jmp = 1'b1; target = 16'h0010;
    step();
    idle(); call = 1'b1; target = 16'h0100;
    step();
    vectors++;
    if (pc !== 16'h0100 || sp_count !== 3'd1) begin
      errors++;
      $display("FAIL call pc=%h sp=%0d exp pc=0100 sp=1", pc, sp_count);
    end
    idle(); inc = 1'b1;
    step();
    vectors++;
    if (pc !== 16'h0101) begin
      errors++; $display("FAIL call_inc pc=%h exp=0101", pc);
    end
    idle(); ret = 1'b1;
    step();
    vectors++;
    if (pc !== 16'h0011 || sp_count !== 3'd0) begin
      errors++;
      $display("FAIL ret pc=%h sp=%0d exp pc=0011 sp=0", pc, sp_count);
    end
    idle();
  endtask

  task automatic test_overflow_underflow();
    logic [15:0] lifo [4];
    lifo[0] = 16'h0221; lifo[1] = 16'h0211;
    lifo[2] = 16'h0201; lifo[3] = 16'h0001;
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      idle(); call = 1'b1; target = 16'h0200 + 16'(i * 16);
      step();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL call%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
    vectors++;
    if (pc !== 16'h0230 || sp_count !== 3'd4 || stack_full !== 1'b1 ||
        overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf pc=%h sp=%0d full=%b ovf=%b exp 0230/4/1/1",
               pc, sp_count, stack_full, overflow);
    end
    for (int i = 0; i < 5; i++) begin
      idle(); ret = 1'b1;
      step();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL ret%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
      if (i < 4) begin
        vectors++;
        if (pc !== lifo[i] || overflow !== 1'b1) begin
          errors++;
          $display("FAIL lifo%0d pc=%h ovf=%b exp pc=%h ovf=1",
                   i, pc, overflow, lifo[i]);
        end
      end
    end
    vectors++;
    if (pc !== 16'h0001 || underflow !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL unf pc=%h unf=%b ovf=%b exp 0001/1/1",
               pc, underflow, overflow);
    end
    idle();
  endtask

  task automatic test_priority();
    pulse_reset();
    jmp = 1'b1; target = 16'hFFFF;
    step();
    idle(); inc = 1'b1;
    step();
    vectors++;
    if (pc !== 16'h0000) begin
      errors++; $display("FAIL wrap pc=%h exp=0000", pc);
    end
    idle(); jmp = 1'b1; target = 16'h0040;
    step();
    idle(); stall = 1'b1; inc = 1'b1; jmp = 1'b1; target = 16'h1234;
    step();
    vectors++;
    if (pc !== 16'h0040) begin
      errors++; $display("FAIL stall pc=%h exp=0040", pc);
    end
    idle(); call = 1'b1; target = 16'h0050;
    step();
    idle(); ret = 1'b1; call = 1'b1; inc = 1'b1; target = 16'h0077;
    step();
    vectors++;
    if (pc !== 16'h0041 || sp_count !== 3'd0) begin
      errors++;
      $display("FAIL ret_wins pc=%h sp=%0d exp pc=0041 sp=0", pc, sp_count);
    end
    idle(); sub = 1'b1; offset = 16'h0045;
    step();
    vectors++;
    if (pc !== 16'hFFFC) begin
      errors++; $display("FAIL sub_wrap pc=%h exp=fffc", pc);
    end
    idle();
  endtask

  task automatic test_random();
    pulse_reset();
    for (int n = 0; n < 400; n++) begin
      stall  = ($urandom_range(0, 7) == 0);
      ret    = ($urandom_range(0, 4) == 0);
      call   = ($urandom_range(0, 3) == 0);
      jmp    = ($urandom_range(0, 5) == 0);
      add    = ($urandom_range(0, 3) == 0);
      sub    = ($urandom_range(0, 3) == 0);
      inc    = ($urandom_range(0, 1) == 0);
      offset = 16'($urandom);
      target = 16'($urandom);
      step();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random%0d got=%h exp=%h", n, dut_vec(), exp_vec());
      end
    end
    idle();
  endtask

  task automatic test_async_reset();
    pulse_reset();
    call = 1'b1; target = 16'h0300;
    step();
    target = 16'h0400;
    step();
    idle();
    add = 1'b1; offset = 16'h0005;
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    vectors++;
    if (dut_vec() !== {16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got=%h exp=%h", dut_vec(),
               {16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    end
    idle();
    @(negedge clk);
    reset = 1'b1;
    inc = 1'b1;
    step();
    vectors++;
    if (pc !== 16'h0001 || sp_count !== 3'd0) begin
      errors++;
      $display("FAIL resume pc=%h sp=%0d exp pc=0001 sp=0", pc, sp_count);
    end
    idle();
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    reset   = 1'b0;
    idle();
    model_clear();
    test_reset();
    test_inc();
    test_add_sub();
    test_call_ret();
    test_overflow_underflow();
    test_priority();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
Parametrised successor to the program counter. Keeps the increment, forward-offset and backward-offset updates, and adds absolute jump, call/return through an internal return-address stack, stall, and sticky stack-fault flags. Sits in the fetch stage, feeding the instruction-memory address; control inputs come from the decode/control unit.

Parameters:
WIDTH, 16, PC/offset/target/stack-entry width in bits
DEPTH, 4, return-stack entries (power of 2, >=2)
RESET_VEC, 0, PC value loaded on reset

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
stall  input  1  freeze PC and stack this cycle
inc  input  1  pc <= pc + 1
add  input  1  pc <= pc + offset
sub  input  1  pc <= pc - offset
jmp  input  1  pc <= target
call  input  1  push pc+1, then pc <= target
ret  input  1  pop top of stack into pc
offset  input  WIDTH  unsigned displacement for add/sub
target  input  WIDTH  absolute destination for jmp/call
pc  output  WIDTH  current program counter (registered)
sp_count  output  clog2(DEPTH)+1  number of valid stack entries
stack_full  output  1  sp_count == DEPTH (combinational from sp_count)
stack_empty  output  1  sp_count == 0 (combinational from sp_count)
overflow  output  1  sticky: call attempted while full
underflow  output  1  sticky: ret attempted while empty

Behaviour:
- Reset (reset==0, asynchronous): pc=RESET_VEC, sp_count=0, overflow=0, underflow=0; stack contents are don't-care. A reset asserted mid-operation aborts any update immediately; normal operation resumes on the first rising edge after reset returns to 1.
- All updates occur on the rising clk edge. pc and flags have 1-cycle latency from the control inputs.
- Priority when several controls are high: stall > ret > call > jmp > add > sub > inc > hold. Only the highest-priority control acts.
- stall=1: pc, stack, sp_count and flags all hold.
- ret, stack non-empty: pc <= stack[sp_count-1]; sp_count decrements.
- ret, stack empty: underflow <= 1; pc and sp_count hold.
- call, not full: stack[sp_count] <= pc+1 (mod 2^WIDTH); sp_count increments; pc <= target.
- call, full: overflow <= 1; no push; pc and sp_count hold (the call is suppressed).
- jmp: pc <= target.
- add: pc <= pc + offset.
- sub: pc <= pc - offset.
- inc: pc <= pc + 1.
- No control high: pc holds.
- Arithmetic is unsigned modulo 2^WIDTH; wrap-around is silent. Examples: 16'hFFFF + 1 = 16'h0000; 16'h0003 - 16'h0005 = 16'hFFFE.
- overflow and underflow clear only on reset.
- Full and empty conditions depend only on sp_count, never on stack contents.

Test Plan:
- Reset then inc, inc, inc with WIDTH=16, RESET_VEC=0 -> pc = 0,1,2,3 on successive edges; sp_count=0, stack_empty=1.
- From pc=1: add with offset=16'h00A5 -> pc=16'h00A6; then sub with offset=16'h0014 -> pc=16'h0092; then idle cycle -> pc holds at 16'h0092.
- From pc=16'h0010: call target=16'h0100 -> pc=16'h0100, sp_count=1; inc -> 16'h0101; ret -> pc=16'h0011, sp_count=0.
- Five calls with DEPTH=4 -> after 4 calls stack_full=1; 5th call leaves pc and sp_count unchanged and sets overflow=1. Then 4 rets return the pushed addresses in LIFO order; a 5th ret sets underflow=1 and pc holds. overflow stays 1 throughout.
- Priority and stall: pc=16'hFFFF with inc -> pc=16'h0000 (wrap). stall+inc+jmp high together -> pc holds. ret+call+inc high together with 1 stack entry -> ret wins.
- Reset driven low asynchronously mid-cycle, after two calls -> pc=RESET_VEC, sp_count=0, overflow/underflow=0 immediately, without waiting for a clk edge.
